// File: rtl/elastic_config_loader_pkg.sv
// rtl/elastic_config_loader_pkg.sv - shared types and constants for the config loader
package elastic_config_loader_pkg;

  localparam int PE_ID_W   = 4;
  localparam int CTX_W     = 3;
  localparam int NSEL_W    = 2;
  localparam int NMASK_W   = 4;
  localparam int OP_W      = 4;
  localparam int DATA_W    = 32;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_OR    = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd6;
  localparam logic [OP_W-1:0] OP_PASS  = 4'd7;
  localparam logic [OP_W-1:0] OP_ROUTE = 4'd8;
  localparam logic [OP_W-1:0] OP_MAX   = OP_ROUTE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_START,
    ST_RUN
  } loader_state_e;

  // One incoming context record: the ElasticConfigData fields plus routing info
  typedef struct packed {
    logic [PE_ID_W-1:0] pe_id;
    logic [CTX_W-1:0]   context_index;
    logic [NSEL_W-1:0]  input_PE_index_1;
    logic [NSEL_W-1:0]  input_PE_index_2;
    logic [NMASK_W-1:0] output_PE_index;
    logic [OP_W-1:0]    op;
    logic [DATA_W-1:0]  const_data;
    logic               last;
  } config_record_t;

  function automatic logic [CTX_W-1:0] ctx_max(input logic [CTX_W-1:0] a,
                                               input logic [CTX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elastic_config_loader_decoder.sv
// rtl/elastic_config_loader_decoder.sv - record legality check and one-hot PE strobe
module config_record_decoder
  import elastic_config_loader_pkg::*;
#(
  parameter int PE_NUM                  = 16,
  parameter int PE_ID_BIT_LENGTH        = 4,
  parameter int CONTEXT_SIZE            = 8,
  parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
  parameter int OPERATION_BIT_LENGTH    = 4
) (
  input  logic [PE_ID_BIT_LENGTH-1:0]        i_pe_id,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] i_context_index,
  input  logic [OPERATION_BIT_LENGTH-1:0]    i_op,
  output logic                               o_record_ok,
  output logic [PE_NUM-1:0]                  o_strobe
);

  logic w_pe_ok;
  logic w_ctx_ok;
  logic w_op_ok;

  // Widen before comparing so PE_NUM / CONTEXT_SIZE need not be powers of two
  assign w_pe_ok     = 32'(i_pe_id) < PE_NUM;
  assign w_ctx_ok    = 32'(i_context_index) < CONTEXT_SIZE;
  assign w_op_ok     = 32'(i_op) <= 32'(OP_MAX);
  assign o_record_ok = w_pe_ok & w_ctx_ok & w_op_ok;

  // One-hot strobe for the addressed PE; all-zero for a rejected record
  always_comb begin
    o_strobe = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      o_strobe[i] = o_record_ok && (32'(i_pe_id) == i);
    end
  end

endmodule

// File: rtl/elastic_config_loader.sv
// rtl/elastic_config_loader.sv - streams context records into PE config memories
module elastic_config_loader
  import elastic_config_loader_pkg::*;
#(
  parameter int PE_NUM                     = 16,
  parameter int PE_ID_BIT_LENGTH           = 4,
  parameter int NEIGHBOR_PE_NUM            = 4,
  parameter int NEIGHBOR_PE_NUM_BIT_LENGTH = 2,
  parameter int OPERATION_BIT_LENGTH       = 4,
  parameter int DATA_WIDTH                 = 32,
  parameter int CONTEXT_SIZE               = 8,
  parameter int CONTEXT_SIZE_BIT_LENGTH    = 3
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [PE_ID_BIT_LENGTH-1:0]           rec_pe_id,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    rec_context_index,
  input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] rec_input_PE_index_1,
  input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] rec_input_PE_index_2,
  input  logic [NEIGHBOR_PE_NUM-1:0]            rec_output_PE_index,
  input  logic [OPERATION_BIT_LENGTH-1:0]       rec_op,
  input  logic [DATA_WIDTH-1:0]                 rec_const_data,
  input  logic                                  rec_last,
  input  logic                                  rec_valid,
  output logic                                  rec_stop,
  input  logic                                  reload,
  output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
  output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]            config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
  output logic [DATA_WIDTH-1:0]                 config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
  output logic [PE_NUM-1:0]                     write_config_data,
  output logic                                  start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,
  output logic                                  busy,
  output logic                                  error
);

  loader_state_e                          r_state;
  logic                                   r_stop;
  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0]  r_in1;
  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0]  r_in2;
  logic [NEIGHBOR_PE_NUM-1:0]             r_out_mask;
  logic [OPERATION_BIT_LENGTH-1:0]        r_op;
  logic [DATA_WIDTH-1:0]                  r_const;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]     r_index;
  logic [PE_NUM-1:0]                      r_strobe;
  logic                                   r_start;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]     r_max_id;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]     r_mapping_max;
  logic                                   r_busy;
  logic                                   r_error;

  config_record_t                         w_rec;
  logic                                   w_accept;
  logic                                   w_record_ok;
  logic [PE_NUM-1:0]                      w_strobe;

  assign w_rec = '{
    pe_id:            rec_pe_id,
    context_index:    rec_context_index,
    input_PE_index_1: rec_input_PE_index_1,
    input_PE_index_2: rec_input_PE_index_2,
    output_PE_index:  rec_output_PE_index,
    op:               rec_op,
    const_data:       rec_const_data,
    last:             rec_last
  };

  assign w_accept = rec_valid & ~r_stop;

  config_record_decoder #(
    .PE_NUM                  (PE_NUM),
    .PE_ID_BIT_LENGTH        (PE_ID_BIT_LENGTH),
    .CONTEXT_SIZE            (CONTEXT_SIZE),
    .CONTEXT_SIZE_BIT_LENGTH (CONTEXT_SIZE_BIT_LENGTH),
    .OPERATION_BIT_LENGTH    (OPERATION_BIT_LENGTH)
  ) u_decoder (
    .i_pe_id         (w_rec.pe_id),
    .i_context_index (w_rec.context_index),
    .i_op            (w_rec.op),
    .o_record_ok     (w_record_ok),
    .o_strobe        (w_strobe)
  );

  // Loader FSM with registered config bus, strobe, start pulse and max-id tracking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_stop        <= 1'b0;
      r_in1         <= '0;
      r_in2         <= '0;
      r_out_mask    <= '0;
      r_op          <= '0;
      r_const       <= '0;
      r_index       <= '0;
      r_strobe      <= '0;
      r_start       <= 1'b0;
      r_max_id      <= '0;
      r_mapping_max <= '0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_strobe <= '0;
      r_start  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_accept) begin
            // A rejected record leaves the config bus untouched
            if (w_record_ok) begin
              r_in1      <= w_rec.input_PE_index_1;
              r_in2      <= w_rec.input_PE_index_2;
              r_out_mask <= w_rec.output_PE_index;
              r_op       <= w_rec.op;
              r_const    <= w_rec.const_data;
              r_index    <= w_rec.context_index;
              r_strobe   <= w_strobe;
            end
            // The first record of a load restarts error and max-id accounting
            if (r_state == ST_IDLE) begin
              r_error  <= ~w_record_ok;
              r_max_id <= w_record_ok ? w_rec.context_index : '0;
            end else begin
              if (!w_record_ok) r_error <= 1'b1;
              if (w_record_ok)  r_max_id <= ctx_max(r_max_id, w_rec.context_index);
            end
            r_busy <= 1'b1;
            if (w_rec.last) begin
              r_state <= ST_SETTLE;
              r_stop  <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_SETTLE: begin
          r_state       <= ST_START;
          r_start       <= 1'b1;
          r_mapping_max <= r_max_id;
        end
        ST_START: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
        ST_RUN: begin
          if (reload) begin
            r_state <= ST_IDLE;
            r_stop  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_stop  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rec_stop                = r_stop;
  assign config_input_PE_index_1 = r_in1;
  assign config_input_PE_index_2 = r_in2;
  assign config_output_PE_index  = r_out_mask;
  assign config_op               = r_op;
  assign config_const_data       = r_const;
  assign config_index            = r_index;
  assign write_config_data       = r_strobe;
  assign start_exec              = r_start;
  assign mapping_context_max_id  = r_mapping_max;
  assign busy                    = r_busy;
  assign error                   = r_error;

endmodule

// File: doc/elastic_config_loader.md
Name: elastic_config_loader

Overview:
- Upstream feeder for the PE array: accepts a SELF-protocol stream of context records and writes each one into the config memory of one PE.
- Drives each PE's config load interface: config fields, write_config_data, config_index.
- After the last record, computes the global mapping_context_max_id and pulses start_exec so every PE restarts at context 0 together.
- Sits between the host/DMA config stream and the PE grid; one instance per array.

Parameters:
- PE_NUM, 16, number of PEs fed; one write strobe each.
- PE_ID_BIT_LENGTH, 4, width of the PE id field.
- NEIGHBOR_PE_NUM, 4, neighbour count; width of the output-enable mask.
- NEIGHBOR_PE_NUM_BIT_LENGTH, 2, width of the input-select fields.
- OPERATION_BIT_LENGTH, 4, opcode width.
- DATA_WIDTH, 32, const field width.
- CONTEXT_SIZE, 8, contexts per PE.
- CONTEXT_SIZE_BIT_LENGTH, 3, context index width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset: synchronous, active-low.
- rec_pe_id  in  PE_ID_BIT_LENGTH  target PE.
- rec_context_index  in  CONTEXT_SIZE_BIT_LENGTH  target context slot.
- rec_input_PE_index_1  in  NEIGHBOR_PE_NUM_BIT_LENGTH  operand A source.
- rec_input_PE_index_2  in  NEIGHBOR_PE_NUM_BIT_LENGTH  operand B source.
- rec_output_PE_index  in  NEIGHBOR_PE_NUM  output-enable mask.
- rec_op  in  OPERATION_BIT_LENGTH  opcode.
- rec_const_data  in  DATA_WIDTH  constant.
- rec_last  in  1  final record of this load.
- rec_valid  in  1  SELF valid.
- rec_stop  out  1  SELF stop.
- reload  in  1  leave RUN and accept a new load.
- config_input_PE_index_1  out  NEIGHBOR_PE_NUM_BIT_LENGTH  broadcast to all PEs.
- config_input_PE_index_2  out  NEIGHBOR_PE_NUM_BIT_LENGTH  broadcast to all PEs.
- config_output_PE_index  out  NEIGHBOR_PE_NUM  broadcast to all PEs.
- config_op  out  OPERATION_BIT_LENGTH  broadcast to all PEs.
- config_const_data  out  DATA_WIDTH  broadcast to all PEs.
- config_index  out  CONTEXT_SIZE_BIT_LENGTH  broadcast to all PEs.
- write_config_data  out  PE_NUM  one-hot write strobe.
- start_exec  out  1  one-cycle start pulse.
- mapping_context_max_id  out  CONTEXT_SIZE_BIT_LENGTH  highest context written.
- busy  out  1  high in LOAD, SETTLE or START.
- error  out  1  sticky bad-record flag.

Behaviour:
- Reset: all config outputs, write_config_data, start_exec, mapping_context_max_id, busy and error are 0. State is IDLE. rec_stop is 0.
- Accept condition: a record is accepted when rec_valid & !rec_stop. The stream handshake is SELF: the upstream holds its data while stop is high.
- States: IDLE, LOAD, SETTLE, START, RUN.
- IDLE:
  - rec_stop=0.
  - The first accepted record clears error and clears the max-id register, then is processed as in LOAD. Next state is LOAD, or SETTLE if rec_last is set.
- LOAD:
  - rec_stop=0; throughput is one record per cycle.
  - Record accepted in cycle N: in cycle N+1 the config_* outputs hold its fields and write_config_data[rec_pe_id]=1 for exactly that cycle. Otherwise write_config_data=0. The config_* outputs hold their last value when no write occurs.
  - Max id: on each valid accepted record, max_id <= max(max_id, rec_context_index).
  - An accepted record with rec_last moves to SETTLE.
- Bad records: rec_pe_id >= PE_NUM, rec_context_index >= CONTEXT_SIZE, or rec_op > 8.
  - The record is consumed with no write strobe and no max-id update.
  - error is set and stays 1 until the next load starts.
  - A bad record carrying rec_last still ends the load.
- SETTLE: rec_stop=1. This cycle carries the final write strobe. Go to START.
- START:
  - rec_stop=1; start_exec=1 for this cycle only.
  - mapping_context_max_id is updated from max_id in this cycle, so it is valid together with start_exec.
  - Go to RUN.
- RUN:
  - rec_stop=1; mapping_context_max_id is held.
  - reload=1 moves to IDLE next cycle.
  - rec_valid is ignored and the data is held upstream.
- reload is ignored in every state other than RUN.
- Latency: last accepted record to start_exec is exactly 2 cycles (strobe at N+1, start_exec at N+2).
- Empty load: not possible; a load always contains at least one record.
- Reset mid-load: returns to IDLE with no strobe. Partially written PE contexts are not cleaned up; the PEs' own reset or the next load overwrites them.
- Duplicate (pe, context) records: written twice; the last record wins.

Decomposition:
- Shared param package:
  - opcode constants OP_NOP..OP_ROUTE (0..8) and OP_MAX=8;
  - loader state enum;
  - a packed ConfigRecord struct mirroring ElasticConfigData plus pe_id and last.
- One natural sub-module, config_record_decoder (combinational):
  - range/opcode check producing record_ok;
  - one-hot strobe generation.
- The FSM, the output registers and the max-id register stay in the top module.

Test Plan:
1. Three records (pe 0 ctx 0 op 1; pe 0 ctx 1 op 3; pe 5 ctx 2 op 5, const 0x2A, last) sent back-to-back:
   - write_config_data = 0x0001, 0x0001, 0x0020 on consecutive cycles;
   - start_exec exactly 2 cycles after the last accept;
   - mapping_context_max_id=2; error=0.
2. Upstream stalls with rec_valid gaps between records:
   - one strobe per accepted record, none in gap cycles;
   - config_* outputs hold between writes.
3. Record with pe_id=15 when PE_NUM=12, then a valid last record on ctx 4:
   - no strobe for the bad record; error=1; max_id=4;
   - error clears on the first accept after reload.
4. In RUN, hold rec_valid=1 for 5 cycles and then pulse reload:
   - rec_stop=1 until IDLE; the record is accepted the cycle after reload;
   - a new load starts with max_id reset.
5. Assert reset_n=0 for one cycle mid-LOAD:
   - next cycle all outputs are 0 and the state is IDLE;
   - no start_exec is produced.
6. Single record, pe 3 ctx 7, last:
   - strobe 0x0008, then start_exec;
   - mapping_context_max_id=7 (wrap boundary).
